// File: rtl/mmio_io_responder_v1.sv
// mmio_io_responder_v1
// Memory-mapped I/O responder on the core data-memory port. Owns the board
// switches, four debounced buttons and eight seven-segment digits, exposed
// through a small word-aligned register window at BASE_ADDR. Anything outside
// the window, misaligned, or a store to a read-only register gets an error
// response and leaves all state untouched.

module mmio_io_responder_v1 #(
   parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   input  logic [15:0] switch_array,
   input  logic        button0,
   input  logic        button1,
   input  logic        button2,
   input  logic        button3,
   output logic [6:0]  seg0,
   output logic [6:0]  seg1,
   output logic [6:0]  seg2,
   output logic [6:0]  seg3,
   output logic [6:0]  seg4,
   output logic [6:0]  seg5,
   output logic [6:0]  seg6,
   output logic [6:0]  seg7
);

   // Debounce counter only ever needs to reach DEBOUNCE_CYCLES-1.
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Register selects, taken from word offset bits [4:2].
   localparam logic [2:0] SEL_SWITCH    = 3'd0;
   localparam logic [2:0] SEL_BTN_LEVEL = 3'd1;
   localparam logic [2:0] SEL_BTN_EVENT = 3'd2;
   localparam logic [2:0] SEL_HEX_DATA  = 3'd3;
   localparam logic [2:0] SEL_HEX_EN    = 3'd4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_t;

   // Active-low g..a glyphs for hex digits 0-F.
   function automatic logic [6:0] hex_glyph(input logic [3:0] value);
      logic [6:0] glyph;
      case (value)
         4'h0:    glyph = 7'h40;
         4'h1:    glyph = 7'h79;
         4'h2:    glyph = 7'h24;
         4'h3:    glyph = 7'h30;
         4'h4:    glyph = 7'h19;
         4'h5:    glyph = 7'h12;
         4'h6:    glyph = 7'h02;
         4'h7:    glyph = 7'h78;
         4'h8:    glyph = 7'h00;
         4'h9:    glyph = 7'h10;
         4'hA:    glyph = 7'h08;
         4'hB:    glyph = 7'h03;
         4'hC:    glyph = 7'h46;
         4'hD:    glyph = 7'h21;
         4'hE:    glyph = 7'h06;
         4'hF:    glyph = 7'h0E;
         default: glyph = 7'h7F;
      endcase
      return glyph;
   endfunction

   state_t                  state_r;
   state_t                  state_n_s;
   logic                    accept_s;
   logic                    req_ready_s;
   logic                    resp_valid_s;

   logic [31:0]             resp_rdata_r;
   logic                    resp_error_r;

   logic [15:0]             sw_meta_r;
   logic [15:0]             sw_sync_r;

   logic [3:0]              btn_raw_s;
   logic [3:0]              btn_meta_r;
   logic [3:0]              btn_sync_r;
   logic [3:0]              btn_stable_r;
   logic [3:0]              btn_stable_n_s;
   logic [3:0][CNT_W-1:0]   btn_cnt_r;
   logic [3:0][CNT_W-1:0]   btn_cnt_n_s;
   logic [3:0]              btn_rise_s;
   logic [3:0]              btn_event_r;
   logic [3:0]              evt_clr_s;

   logic [31:0]             hex_data_r;
   logic [7:0]              hex_en_r;
   logic [7:0][6:0]         seg_r;

   logic [31:0]             off_s;
   logic [2:0]              sel_s;
   logic                    map_ok_s;
   logic                    dec_err_s;
   logic [31:0]             rd_data_s;
   logic                    acc_wr_s;
   logic                    hex_data_we_s;
   logic                    hex_en_we_s;

   assign btn_raw_s = {button3, button2, button1, button0};

   // Handshake FSM next state and ready/valid decode.
   always_comb begin
      state_n_s    = state_r;
      accept_s     = 1'b0;
      req_ready_s  = 1'b0;
      resp_valid_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            req_ready_s = 1'b1;
            if (req_valid) begin
               accept_s  = 1'b1;
               state_n_s = ST_RESP;
            end else begin
               state_n_s = ST_IDLE;
            end
         end
         ST_RESP: begin
            resp_valid_s = 1'b1;
            if (resp_ready) begin
               state_n_s = ST_IDLE;
            end else begin
               state_n_s = ST_RESP;
            end
         end
         default: begin
            state_n_s = ST_IDLE;
         end
      endcase
   end

   // Handshake FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_n_s;
      end
   end

   // Address decode, error classification and read-data mux.
   always_comb begin
      off_s     = req_addr - BASE_ADDR;
      sel_s     = off_s[4:2];
      map_ok_s  = (off_s[1:0] == 2'b00) && (off_s[31:5] == 27'd0) && (off_s[4:0] <= 5'h10);
      dec_err_s = 1'b0;
      rd_data_s = 32'h0000_0000;
      if (!map_ok_s) begin
         dec_err_s = 1'b1;
      end else begin
         case (sel_s)
            SEL_SWITCH: begin
               rd_data_s = {16'h0000, sw_sync_r};
               dec_err_s = req_write;
            end
            SEL_BTN_LEVEL: begin
               rd_data_s = {28'h000_0000, btn_stable_r};
               dec_err_s = req_write;
            end
            SEL_BTN_EVENT: begin
               // Include a rise landing on this very edge in the snapshot.
               rd_data_s = {28'h000_0000, btn_event_r | btn_rise_s};
            end
            SEL_HEX_DATA: begin
               rd_data_s = hex_data_r;
            end
            SEL_HEX_EN: begin
               rd_data_s = {24'h00_0000, hex_en_r};
            end
            default: begin
               dec_err_s = 1'b1;
            end
         endcase
      end
   end

   // Write strobes for an accepted, error-free store.
   always_comb begin
      acc_wr_s      = accept_s & req_write & ~dec_err_s;
      hex_data_we_s = acc_wr_s && (sel_s == SEL_HEX_DATA);
      hex_en_we_s   = acc_wr_s && (sel_s == SEL_HEX_EN);
      if (acc_wr_s && (sel_s == SEL_BTN_EVENT)) begin
         evt_clr_s = req_wdata[3:0];
      end else begin
         evt_clr_s = 4'h0;
      end
   end

   // Capture the response at the accepting edge and hold it through RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resp_rdata_r <= 32'h0000_0000;
         resp_error_r <= 1'b0;
      end else if (accept_s) begin
         resp_rdata_r <= (req_write || dec_err_s) ? 32'h0000_0000 : rd_data_s;
         resp_error_r <= dec_err_s;
      end else begin
         resp_rdata_r <= resp_rdata_r;
         resp_error_r <= resp_error_r;
      end
   end

   // Two-flop synchronizers for switches and buttons.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_meta_r  <= 16'h0000;
         sw_sync_r  <= 16'h0000;
         btn_meta_r <= 4'h0;
         btn_sync_r <= 4'h0;
      end else begin
         sw_meta_r  <= switch_array;
         sw_sync_r  <= sw_meta_r;
         btn_meta_r <= btn_raw_s;
         btn_sync_r <= btn_meta_r;
      end
   end

   // Per-button debounce: count while synced differs from stable, accept at threshold.
   always_comb begin
      btn_stable_n_s = btn_stable_r;
      btn_cnt_n_s    = btn_cnt_r;
      btn_rise_s     = 4'h0;
      for (int i = 0; i < 4; i++) begin
         if (btn_sync_r[i] == btn_stable_r[i]) begin
            btn_cnt_n_s[i] = '0;
         end else if (btn_cnt_r[i] == CNT_MAX) begin
            btn_stable_n_s[i] = btn_sync_r[i];
            btn_cnt_n_s[i]    = '0;
            btn_rise_s[i]     = btn_sync_r[i];
         end else begin
            btn_cnt_n_s[i] = btn_cnt_r[i] + CNT_W'(1);
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_stable_r <= 4'h0;
         btn_cnt_r    <= '0;
      end else begin
         btn_stable_r <= btn_stable_n_s;
         btn_cnt_r    <= btn_cnt_n_s;
      end
   end

   // Sticky button events; a rise beats a same-cycle W1C clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_event_r <= 4'h0;
      end else begin
         btn_event_r <= (btn_event_r & ~evt_clr_s) | btn_rise_s;
      end
   end

   // Display registers written by stores.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hex_data_r <= 32'h0000_0000;
         hex_en_r   <= 8'h00;
      end else begin
         if (hex_data_we_s) begin
            hex_data_r <= req_wdata;
         end else begin
            hex_data_r <= hex_data_r;
         end
         if (hex_en_we_s) begin
            hex_en_r <= req_wdata[7:0];
         end else begin
            hex_en_r <= hex_en_r;
         end
      end
   end

   // Registered seven-segment drive; disabled digits are blank.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 8; k++) begin
            seg_r[k] <= 7'h7F;
         end
      end else begin
         for (int k = 0; k < 8; k++) begin
            seg_r[k] <= hex_en_r[k] ? hex_glyph(hex_data_r[4*k +: 4]) : 7'h7F;
         end
      end
   end

   assign req_ready  = req_ready_s;
   assign resp_valid = resp_valid_s;
   assign resp_rdata = resp_rdata_r;
   assign resp_error = resp_error_r;

   assign seg0 = seg_r[0];
   assign seg1 = seg_r[1];
   assign seg2 = seg_r[2];
   assign seg3 = seg_r[3];
   assign seg4 = seg_r[4];
   assign seg5 = seg_r[5];
   assign seg6 = seg_r[6];
   assign seg7 = seg_r[7];

endmodule

// File: tb/tb_mmio_io_responder_v1.sv
// Directed testbench for mmio_io_responder_v1 with hand-computed expectations.

module tb_mmio_io_responder_v1;

   localparam logic [31:0] BASE = 32'hFFFF_0000;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic [15:0] switch_array;
   logic        button0;
   logic        button1;
   logic        button2;
   logic        button3;
   logic [6:0]  seg [8];

   int assert_cnt = 0;
   int fail_cnt   = 0;

   // Expected display patterns, digit 7 in the top slice.
   localparam logic [55:0] SEGS_BLANK   = {8{7'h7F}};
   localparam logic [55:0] SEGS_ALL     = {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
   localparam logic [55:0] SEGS_ONLY0   = {{7{7'h7F}}, 7'h79};

   mmio_io_responder_v1 #(
      .BASE_ADDR       (BASE),
      .DEBOUNCE_CYCLES (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_error   (resp_error),
      .switch_array (switch_array),
      .button0      (button0),
      .button1      (button1),
      .button2      (button2),
      .button3      (button3),
      .seg0         (seg[0]),
      .seg1         (seg[1]),
      .seg2         (seg[2]),
      .seg3         (seg[3]),
      .seg4         (seg[4]),
      .seg5         (seg[5]),
      .seg6         (seg[6]),
      .seg7         (seg[7])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_segs(input string tag, input logic [55:0] exp);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("%s_seg%0d", tag, k), {25'd0, seg[k]}, {25'd0, exp[7*k +: 7]});
      end
   endtask

   // One request with resp_ready high; called at a negedge, returns two negedges later.
   task automatic bus(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
      chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, "_rdata"}, resp_rdata, exp_rd);
      chk({tag, "_error"}, {31'd0, resp_error}, {31'd0, exp_err});
      @(negedge clk);
   endtask

   initial begin
      rst          = 1'b0;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_addr     = 32'h0000_0000;
      req_wdata    = 32'h0000_0000;
      resp_ready   = 1'b1;
      switch_array = 16'h0000;
      button0      = 1'b0;
      button1      = 1'b0;
      button2      = 1'b0;
      button3      = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_error", {31'd0, resp_error}, 32'd0);
      check_segs("rst", SEGS_BLANK);
      rst = 1'b1;
      @(negedge clk);
      bus(1'b0, BASE + 32'h0C, 32'h0, 32'h0, 1'b0, "rd_hexd_rst");
      bus(1'b0, BASE + 32'h08, 32'h0, 32'h0, 1'b0, "rd_evt_rst");

      // Display writes
      bus(1'b1, BASE + 32'h0C, 32'h8765_4321, 32'h0, 1'b0, "wr_hexd");
      bus(1'b1, BASE + 32'h10, 32'h0000_00FF, 32'h0, 1'b0, "wr_hexen_ff");
      check_segs("all_on", SEGS_ALL);
      bus(1'b1, BASE + 32'h10, 32'hFFFF_FF01, 32'h0, 1'b0, "wr_hexen_01");
      check_segs("only0", SEGS_ONLY0);
      bus(1'b0, BASE + 32'h10, 32'h0, 32'h0000_0001, 1'b0, "rd_hexen_mask");

      // Error responses leave state alone
      bus(1'b0, BASE + 32'h02, 32'h0, 32'h0, 1'b1, "err_misal_rd");
      bus(1'b1, BASE + 32'h00, 32'hFFFF_FFFF, 32'h0, 1'b1, "err_wr_switch");
      bus(1'b1, BASE + 32'h04, 32'hFFFF_FFFF, 32'h0, 1'b1, "err_wr_level");
      bus(1'b0, BASE + 32'h14, 32'h0, 32'h0, 1'b1, "err_oor_rd");
      bus(1'b1, BASE + 32'h0E, 32'h0, 32'h0, 1'b1, "err_misal_wr");
      bus(1'b1, BASE + 32'h14, 32'h0, 32'h0, 1'b1, "err_oor_wr");
      bus(1'b0, BASE - 32'h04, 32'h0, 32'h0, 1'b1, "err_below");
      bus(1'b0, BASE + 32'h0C, 32'h0, 32'h8765_4321, 1'b0, "rd_hexd_kept");
      bus(1'b0, BASE + 32'h10, 32'h0, 32'h0000_0001, 1'b0, "rd_hexen_kept");
      check_segs("kept", SEGS_ONLY0);
      bus(1'b0, BASE + 32'h00, 32'h0, 32'h0, 1'b0, "rd_switch_zero");

      // Backpressure: response held five cycles
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_addr   = BASE + 32'h0C;
      @(negedge clk);
      req_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp_valid_%0d", c), {31'd0, resp_valid}, 32'd1);
         chk($sformatf("bp_ready_%0d", c), {31'd0, req_ready}, 32'd0);
         chk($sformatf("bp_rdata_%0d", c), resp_rdata, 32'h8765_4321);
         chk($sformatf("bp_error_%0d", c), {31'd0, resp_error}, 32'd0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", {31'd0, resp_valid}, 32'd0);
      chk("bp_release_ready", {31'd0, req_ready}, 32'd1);

      // Debounce on button2: a short bounce, then a clean press
      button2 = 1'b1;
      repeat (10) @(negedge clk);
      button2 = 1'b0;
      repeat (2) @(negedge clk);
      bus(1'b0, BASE + 32'h08, 32'h0, 32'h0, 1'b0, "bounce_evt");
      @(negedge clk);
      button2 = 1'b1;
      repeat (15) @(negedge clk);
      bus(1'b0, BASE + 32'h04, 32'h0, 32'h0, 1'b0, "b2_lvl_e16");
      bus(1'b0, BASE + 32'h08, 32'h0, 32'h4, 1'b0, "b2_evt_e18");
      bus(1'b0, BASE + 32'h04, 32'h0, 32'h4, 1'b0, "b2_lvl_after");
      bus(1'b1, BASE + 32'h08, 32'h4, 32'h0, 1'b0, "b2_w1c");
      bus(1'b0, BASE + 32'h08, 32'h0, 32'h0, 1'b0, "b2_evt_cleared");

      // Set wins over a W1C on the same edge (button0 rises at edge 18)
      button0 = 1'b1;
      repeat (15) @(negedge clk);
      bus(1'b0, BASE + 32'h04, 32'h0, 32'h4, 1'b0, "b0_lvl_e16");
      bus(1'b1, BASE + 32'h08, 32'h1, 32'h0, 1'b0, "b0_w1c_e18");
      bus(1'b0, BASE + 32'h08, 32'h0, 32'h1, 1'b0, "b0_evt_kept");
      bus(1'b0, BASE + 32'h04, 32'h0, 32'h5, 1'b0, "b0_lvl_after");

      // Switch sample
      switch_array = 16'hA5C3;
      repeat (2) @(negedge clk);
      bus(1'b0, BASE + 32'h00, 32'h0, 32'h0000_A5C3, 1'b0, "rd_switch");

      // Reset while a response is pending
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_addr   = BASE + 32'h00;
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort_pre_valid", {31'd0, resp_valid}, 32'd1);
      chk("abort_pre_rdata", resp_rdata, 32'h0000_A5C3);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_valid", {31'd0, resp_valid}, 32'd0);
      chk("abort_ready", {31'd0, req_ready}, 32'd1);
      chk("abort_rdata", resp_rdata, 32'h0);
      check_segs("abort", SEGS_BLANK);
      @(negedge clk);
      rst        = 1'b1;
      resp_ready = 1'b1;
      @(negedge clk);
      bus(1'b0, BASE + 32'h10, 32'h0, 32'h0, 1'b0, "post_rst_hexen");
      bus(1'b0, BASE + 32'h0C, 32'h0, 32'h0, 1'b0, "post_rst_hexd");

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
